// File: rtl/vga_timing_if.sv
// Raster timing bundle: pix_en paces the generator, the rest describes the pixel being presented.
// There is no valid/ready pair; pix_en qualifies each advance and consumers cannot stall the raster.
interface vga_timing_if;
   logic        pix_en;
   logic        hsync;
   logic        vsync;
   logic        active;
   logic [10:0] p_x;
   logic [9:0]  p_y;
   logic        line_end;
   logic        frame_start;
   logic [7:0]  frame_count;

   modport master (
      input  pix_en,
      output hsync, vsync, active, p_x, p_y, line_end, frame_start, frame_count
   );

   modport slave (
      output pix_en,
      input  hsync, vsync, active, p_x, p_y, line_end, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// SVGA raster timing generator: pixel/line counters with every output registered
// from the next-state coordinates so sync, active and position never skew.
module vga_timing_gen #(
   parameter int H_VISIBLE = 800,
   parameter int H_FRONT   = 56,
   parameter int H_SYNC    = 120,
   parameter int H_BACK    = 64,
   parameter int V_VISIBLE = 600,
   parameter int V_FRONT   = 37,
   parameter int V_SYNC    = 6,
   parameter int V_BACK    = 23,
   parameter bit SYNC_POL  = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   vga_timing_if.master vga
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [10:0] x_next;
   logic [9:0]  y_next;
   logic        fs_next;
   logic        hs_next;
   logic        vs_next;
   logic        act_next;

   always_comb begin
      x_next = vga.p_x + 11'd1;
      y_next = vga.p_y;
      if (vga.p_x == H_LAST) begin
         x_next = '0;
         y_next = (vga.p_y == V_LAST) ? 10'd0 : vga.p_y + 10'd1;
      end
      fs_next  = (x_next == 11'd0) && (y_next == 10'd0);
      hs_next  = (x_next >= HS_START) && (x_next < HS_END);
      vs_next  = (y_next >= VS_START) && (y_next < VS_END);
      act_next = (x_next < H_VIS) && (y_next < V_VIS);
   end

   // Reset parks on the last pixel of the frame so the first advance lands on (0,0).
   always_ff @(posedge clk) begin
      if (!reset) begin
         vga.p_x         <= H_LAST;
         vga.p_y         <= V_LAST;
         vga.active      <= 1'b0;
         vga.hsync       <= ~SYNC_POL;
         vga.vsync       <= ~SYNC_POL;
         vga.line_end    <= 1'b1;
         vga.frame_start <= 1'b0;
         vga.frame_count <= 8'd0;
      end else if (vga.pix_en) begin
         vga.p_x         <= x_next;
         vga.p_y         <= y_next;
         vga.active      <= act_next;
         vga.hsync       <= hs_next ? SYNC_POL : ~SYNC_POL;
         vga.vsync       <= vs_next ? SYNC_POL : ~SYNC_POL;
         vga.line_end    <= (x_next == H_LAST);
         vga.frame_start <= fs_next;
         vga.frame_count <= vga.frame_count + 8'(fs_next);
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a shrunken,
// negative-polarity instance for frame-level behaviour, both checked every cycle.
module tb_vga_timing_gen;
   localparam int A_HT = 1040;
   localparam int A_T  = 1040 * 666;
   localparam int B_HT = 15;
   localparam int B_T  = 15 * 9;

   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;

   vga_timing_if ifa ();
   vga_timing_if ifb ();

   vga_timing_gen dut_a (
      .clk   (clk),
      .reset (reset_a),
      .vga   (ifa)
   );

   vga_timing_gen #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_VISIBLE (5), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
      .SYNC_POL  (1'b0)
   ) dut_b (
      .clk   (clk),
      .reset (reset_b),
      .vga   (ifb)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   int pos_a = A_T - 1;
   int fr_a  = 0;
   int pos_b = B_T - 1;
   int fr_b  = 0;

   logic [33:0] obs_a;
   logic [33:0] obs_b;
   assign obs_a = {ifa.hsync, ifa.vsync, ifa.active, ifa.line_end, ifa.frame_start,
                   ifa.p_x, ifa.p_y, ifa.frame_count};
   assign obs_b = {ifb.hsync, ifb.vsync, ifb.active, ifb.line_end, ifb.frame_start,
                   ifb.p_x, ifb.p_y, ifb.frame_count};

   task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Raster position as a linear pixel index; coordinates and flags follow by arithmetic.
   function automatic logic [33:0] model_out(input int hv, input int hf, input int hs,
                                             input int vv, input int vf, input int vs,
                                             input int ht, input bit pol,
                                             input int pos, input int frames);
      int x = pos % ht;
      int y = pos / ht;
      bit hs_on = (x >= hv + hf) && (x < hv + hf + hs);
      bit vs_on = (y >= vv + vf) && (y < vv + vf + vs);
      bit act   = (x < hv) && (y < vv);
      bit le    = (x == ht - 1);
      bit fs    = (pos == 0);
      return {(hs_on ? pol : ~pol), (vs_on ? pol : ~pol), act, le, fs,
              11'(x), 10'(y), 8'(frames)};
   endfunction

   task automatic step(input bit ra, input bit ea, input bit rb, input bit eb);
      reset_a    = ra;
      ifa.pix_en = ea;
      reset_b    = rb;
      ifb.pix_en = eb;
      @(posedge clk);
      if (!ra) begin
         pos_a = A_T - 1;
         fr_a  = 0;
      end else if (ea) begin
         pos_a = (pos_a + 1) % A_T;
         if (pos_a == 0) fr_a = (fr_a + 1) % 256;
      end
      if (!rb) begin
         pos_b = B_T - 1;
         fr_b  = 0;
      end else if (eb) begin
         pos_b = (pos_b + 1) % B_T;
         if (pos_b == 0) fr_b = (fr_b + 1) % 256;
      end
      @(negedge clk);
      check("a_raster", obs_a, model_out(800, 56, 120, 600, 37, 6, A_HT, 1'b1, pos_a, fr_a));
      check("b_raster", obs_b, model_out(8, 2, 3, 5, 1, 2, B_HT, 1'b0, pos_b, fr_b));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int act_n    = 0;
      int hs_n     = 0;
      int hs_first = -1;
      int le_x     = -1;
      int le_n     = 0;
      bit found    = 1'b0;
      int pulses   = 0;
      int last_p   = 0;
      int vs_n     = 0;
      int act_b    = 0;

      // Reset both generators.
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
      check("rst_px", 34'(ifa.p_x), 34'(1039));
      check("rst_py", 34'(ifa.p_y), 34'(665));
      check("rst_sync", 34'({ifa.hsync, ifa.vsync, ifa.active}), 34'(0));

      // One full line plus the wrap onto line 1.
      for (int i = 0; i <= 1040; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1);
         if (i == 0) begin
            check("first_px", 34'(ifa.p_x), 34'(0));
            check("first_active", 34'(ifa.active), 34'(1));
            check("first_fs", 34'(ifa.frame_start), 34'(1));
            check("first_fc", 34'(ifa.frame_count), 34'(1));
         end
         if (i < 1040) begin
            if (ifa.active) act_n++;
            if (ifa.hsync) begin
               hs_n++;
               if (hs_first < 0) hs_first = int'(ifa.p_x);
            end
            if (ifa.line_end) le_x = int'(ifa.p_x);
         end
      end
      check("line_active_n", 34'(act_n), 34'(800));
      check("line_hsync_n", 34'(hs_n), 34'(120));
      check("hsync_first_x", 34'(hs_first), 34'(856));
      check("line_end_x", 34'(le_x), 34'(1039));
      check("wrap_xy", 34'({ifa.p_x, ifa.p_y}), 34'({11'd0, 10'd1}));

      // 50% pix_en: each pixel held two clocks, two lines in 4160 clocks.
      for (int i = 0; i < 4160; i++) begin
         step(1'b1, (i % 2) == 0, 1'b1, 1'($urandom_range(0, 1)));
         if (ifa.line_end) le_n++;
      end
      check("toggle_line_end_n", 34'(le_n), 34'(4));
      check("toggle_xy", 34'({ifa.p_x, ifa.p_y}), 34'({11'd0, 10'd3}));

      // Reset mid-line with pix_en low.
      for (int i = 0; i < 1100 && !found; i++) begin
         if (pos_a % A_HT == 500) found = 1'b1;
         else step(1'b1, 1'b1, 1'b1, 1'b1);
      end
      check("reach_x500", 34'(found), 34'(1));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("midrst_px", 34'(ifa.p_x), 34'(1039));
      check("midrst_py", 34'(ifa.p_y), 34'(665));
      check("midrst_fc", 34'(ifa.frame_count), 34'(0));
      check("midrst_b_sync", 34'({ifb.hsync, ifb.vsync}), 34'(2'b11));

      // Random pacing with rare resets.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);

      // 256 frames on the small instance: period, counts and frame_count wrap.
      step(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 256 * B_T; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         if (ifb.frame_start) begin
            pulses++;
            if (pulses == 1) check("b_fc1", 34'(ifb.frame_count), 34'(1));
            if (pulses == 2) begin
               check("b_period", 34'(i - last_p), 34'(B_T));
               check("b_fc2", 34'(ifb.frame_count), 34'(2));
               check("b_vsync_n", 34'(vs_n), 34'(30));
               check("b_active_n", 34'(act_b), 34'(40));
            end
            if (pulses == 256) check("b_fc_wrap", 34'(ifb.frame_count), 34'(0));
            last_p = i;
         end
         if (pulses == 1) begin
            if (ifb.vsync == 1'b0) vs_n++;
            if (ifb.active) act_b++;
         end
      end
      check("b_pulses", 34'(pulses), 34'(256));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
